turn_signal_sequencer: RTL and testbench
========================================

# turn_signal_sequencer

Tail-light controller that arbitrates turn, lane-change tap, hazard and brake requests and sequences the three-lamp clusters on each side. It replaces direct left/right FSM control at the lighting top level. An internal prescaler produces the animation tick, and output overlays are registered for glitch-free lamp drive.

## Interface
- TICK_DIV, default 4_000_000: clk cycles per animation tick; minimum 2.
- LANE_SWEEPS, default 3: sweeps issued per lane-change tap; range 1..7.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- left  in  1  level left-turn request
- right  in  1  level right-turn request
- tap_left  in  1  single-cycle lane-change pulse, left
- tap_right  in  1  single-cycle lane-change pulse, right
- hazard  in  1  level hazard request
- brake  in  1  level brake
- l  out  3  left lamps; bit0 is innermost
- r  out  3  right lamps; bit2 is innermost
- busy  out  1  state != IDLE or any tap count nonzero
- tick  out  1  one-cycle animation strobe

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps to 0. tick=1 while the count equals TICK_DIV-1.
- States: IDLE, L1, L2, L3, R1, R2, R3, H_ON, H_OFF. The state changes only on a clk edge where tick=1.
- Each side keeps a 3-bit tap count.
  - A tap loads that side's count with LANE_SWEEPS and clears the opposite count.
  - A tap on the same side reloads the count.
  - tap_left and tap_right in the same cycle: both ignored.
  - Taps are ignored while hazard=1, and both counts are held at 0 while hazard=1.
- Side active: left_act = left | (left_cnt != 0); right_act likewise.
- Transitions taken on tick, first match wins:
  - hazard=1 and state not in {H_ON, H_OFF}: go to H_ON (preempts a sweep).
  - IDLE: left_act & !right_act -> L1. right_act & !left_act -> R1. Otherwise stay in IDLE.
  - L1->L2->L3->IDLE; R1->R2->R3->IDLE. A sweep always completes once started, regardless of request changes.
  - On L3->IDLE, left_cnt decrements if nonzero. R3 does the same for right_cnt.
  - H_ON->H_OFF always. H_OFF->H_ON if hazard=1, else IDLE.
- Base patterns:
  - IDLE: l=000, r=000
  - L1: l=001; L2: l=011; L3: l=111
  - R1: r=100; R2: r=110; R3: r=111
  - H_ON: both sides 111; H_OFF: both sides 000
- Brake overlay applies only to a side not owned by a sweep, and is disabled in H_ON/H_OFF.
  - In IDLE, brake drives l=r=111.
  - In L1..L3, brake drives r=111; in R1..R3, brake drives l=111.

## Timing
- On reset assertion: prescaler=0, state=IDLE, both counts=0, l=000, r=000, busy=0, tick=0.
- Reset takes effect immediately, including mid-sweep. No tick occurs until TICK_DIV cycles after release.
- l and r are registered from (state, brake) and change one clk after a state update.
- Brake to lamp latency is 1 clk.
- A tap is captured on the edge where it is high, so the count is visible on the next cycle.
- A tap coinciding with an L3/R3 decrement on the same side: the load wins.
- Worst-case turn start after a request is 1 tick, or 4 ticks if arriving just after a sweep starts on the other side.

## Structure
- Shared package `tail_light_pkg`:
  - state enum
  - lamp pattern constants: OFF=3'b000, ALL=3'b111, L_SWEEP[1:3], R_SWEEP[1:3]
  - tap-count width constant (3)
- Sub-module `tick_prescaler`:
  - parameter TICK_DIV
  - ports clk, reset, tick
  - counter width $clog2(TICK_DIV)

## Test plan
All scenarios use TICK_DIV=4, LANE_SWEEPS=3.
- Reset, then left=1 held: l sequence is 001, 011, 111, 000, 001…, one step per 4 clk, with r=000 throughout.
- Single tap_right pulse, no levels: exactly 3 full right sweeps (9 lit ticks plus 3 off ticks), then busy=0 and r=000.
- Left sweep in L2, hazard raised: next tick gives l=r=111, then 000 alternating. Drop hazard during H_ON: one H_OFF tick, then IDLE.
- brake=1 during a left sweep: r=111 within 1 clk while l keeps sweeping. Brake in IDLE gives l=r=111; brake during hazard leaves the hazard pattern unchanged.
- left=right=1: stays in IDLE with lamps 000. tap_left and tap_right in the same cycle: counts unchanged and busy=0.
- Assert reset during R2: l=r=000 and busy=0 immediately. After release, first tick arrives after 4 clk.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared types and constants for the tail-light sequencer: FSM states,
// lamp patterns and lane-change tap counter width.
package tail_light_pkg;

    typedef enum logic [3:0] {
        IDLE, L1, L2, L3, R1, R2, R3, H_ON, H_OFF
    } state_t;

    localparam logic [2:0] OFF = 3'b000;
    localparam logic [2:0] ALL = 3'b111;

    // Sweep steps indexed 1..3; left fills outward from bit0, right from bit2.
    localparam logic [3:1][2:0] L_SWEEP = {3'b111, 3'b011, 3'b001};
    localparam logic [3:1][2:0] R_SWEEP = {3'b111, 3'b110, 3'b100};

    localparam int CNT_W = 3;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle animation strobe every
// TICK_DIV clocks; tick is high while the count sits at its last value.
module tick_prescaler #(
    parameter int TICK_DIV = 4_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/turn_signal_sequencer.sv
// Tail-light controller: arbitrates turn, lane-change tap, hazard and brake
// requests, steps the lamp FSM on each animation tick, registers lamp drive.
module turn_signal_sequencer
    import tail_light_pkg::*;
#(
    parameter int TICK_DIV    = 4_000_000,
    parameter int LANE_SWEEPS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       tap_left,
    input  logic       tap_right,
    input  logic       hazard,
    input  logic       brake,
    output logic [2:0] l,
    output logic [2:0] r,
    output logic       busy,
    output logic       tick
);

    localparam logic [CNT_W-1:0] SWEEPS = CNT_W'(LANE_SWEEPS);

    state_t           state, state_next;
    logic [CNT_W-1:0] left_cnt, right_cnt;
    logic [2:0]       l_next, r_next;
    logic             left_act, right_act, left_dec, right_dec;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign left_act  = left  | (left_cnt  != '0);
    assign right_act = right | (right_cnt != '0);
    assign left_dec  = tick && (state == L3) && (left_cnt  != '0);
    assign right_dec = tick && (state == R3) && (right_cnt != '0);
    assign busy      = (state != IDLE) || (left_cnt != '0) || (right_cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A tap load on the same side wins over the end-of-sweep decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_cnt  <= '0;
            right_cnt <= '0;
        end else if (hazard) begin
            left_cnt  <= '0;
            right_cnt <= '0;
        end else if (tap_left && !tap_right) begin
            left_cnt  <= SWEEPS;
            right_cnt <= '0;
        end else if (tap_right && !tap_left) begin
            right_cnt <= SWEEPS;
            left_cnt  <= '0;
        end else begin
            if (left_dec)
                left_cnt <= left_cnt - CNT_W'(1);
            if (right_dec)
                right_cnt <= right_cnt - CNT_W'(1);
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        if (tick) begin
            if (hazard && state != H_ON && state != H_OFF) begin
                state_next = H_ON;
            end else begin
                case (state)
                    IDLE: begin
                        if (left_act && !right_act)
                            state_next = L1;
                        else if (right_act && !left_act)
                            state_next = R1;
                    end
                    L1:      state_next = L2;
                    L2:      state_next = L3;
                    L3:      state_next = IDLE;
                    R1:      state_next = R2;
                    R2:      state_next = R3;
                    R3:      state_next = IDLE;
                    H_ON:    state_next = H_OFF;
                    H_OFF:   state_next = hazard ? H_ON : IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Brake lights whichever side no sweep owns; hazard ignores brake.
    always_comb begin
        l_next = OFF;
        r_next = OFF;
        case (state)
            IDLE: begin
                if (brake) begin
                    l_next = ALL;
                    r_next = ALL;
                end
            end
            L1: begin l_next = L_SWEEP[1]; r_next = brake ? ALL : OFF; end
            L2: begin l_next = L_SWEEP[2]; r_next = brake ? ALL : OFF; end
            L3: begin l_next = L_SWEEP[3]; r_next = brake ? ALL : OFF; end
            R1: begin r_next = R_SWEEP[1]; l_next = brake ? ALL : OFF; end
            R2: begin r_next = R_SWEEP[2]; l_next = brake ? ALL : OFF; end
            R3: begin r_next = R_SWEEP[3]; l_next = brake ? ALL : OFF; end
            H_ON: begin
                l_next = ALL;
                r_next = ALL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l <= OFF;
            r <= OFF;
        end else begin
            l <= l_next;
            r <= r_next;
        end
    end

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Randomized and directed bench for turn_signal_sequencer against a
// cycle-level behavioural model built from side/step bookkeeping.
module tb_turn_signal_sequencer;

    localparam int TD = 4;
    localparam int LS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       left = 1'b0, right = 1'b0, tap_left = 1'b0, tap_right = 1'b0;
    logic       hazard = 1'b0, brake = 1'b0;
    logic [2:0] l, r;
    logic       busy, tick;

    int errors = 0;
    int checks = 0;

    turn_signal_sequencer #(.TICK_DIV(TD), .LANE_SWEEPS(LS)) dut (
        .clk       (clk),
        .reset     (reset),
        .left      (left),
        .right     (right),
        .tap_left  (tap_left),
        .tap_right (tap_right),
        .hazard    (hazard),
        .brake     (brake),
        .l         (l),
        .r         (r),
        .busy      (busy),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: side 0=idle, 1=left sweep, 2=right sweep, 3=hazard.
    // step is 1..3 within a sweep; for hazard 1=lamps on, 0=lamps off.
    int         m_pre, m_side, m_step, m_lc, m_rc;
    logic [2:0] m_l, m_r;

    function automatic logic [2:0] left_lamps(input int side, input int step, input logic brk);
        case (side)
            0, 2:    return brk ? 3'b111 : 3'b000;
            1:       return 3'((1 << step) - 1);
            default: return (step == 1) ? 3'b111 : 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] right_lamps(input int side, input int step, input logic brk);
        case (side)
            0, 1:    return brk ? 3'b111 : 3'b000;
            2:       return 3'(7 - ((1 << (3 - step)) - 1));
            default: return (step == 1) ? 3'b111 : 3'b000;
        endcase
    endfunction

    function automatic logic m_busy();
        return (m_side != 0) || (m_lc != 0) || (m_rc != 0);
    endfunction

    task automatic model_reset();
        m_pre = 0; m_side = 0; m_step = 0; m_lc = 0; m_rc = 0;
        m_l = 3'b000; m_r = 3'b000;
    endtask

    // Checks current outputs, advances one clock, updates the model.
    task automatic cycle();
        int         ns, nst, nlc, nrc;
        logic       on_tick, la, ra, done_l, done_r;
        logic [2:0] nl, nr;
        on_tick = (m_pre == TD - 1);
        check("tick", tick, on_tick);
        check("busy", busy, m_busy());
        check("l", l, m_l);
        check("r", r, m_r);
        ns = m_side; nst = m_step; done_l = 0; done_r = 0;
        la = left  || (m_lc != 0);
        ra = right || (m_rc != 0);
        if (on_tick) begin
            if (hazard && m_side != 3) begin
                ns = 3; nst = 1;
            end else if (m_side == 0) begin
                if (la && !ra) begin ns = 1; nst = 1; end
                else if (ra && !la) begin ns = 2; nst = 1; end
            end else if (m_side == 3) begin
                if (m_step == 1) nst = 0;
                else if (hazard) nst = 1;
                else ns = 0;
            end else if (m_step == 3) begin
                done_l = (m_side == 1);
                done_r = (m_side == 2);
                ns = 0; nst = 0;
            end else begin
                nst = m_step + 1;
            end
        end
        nlc = m_lc; nrc = m_rc;
        if (done_l && nlc > 0) nlc--;
        if (done_r && nrc > 0) nrc--;
        if (tap_left && !tap_right) begin nlc = LS; nrc = 0; end
        else if (tap_right && !tap_left) begin nrc = LS; nlc = 0; end
        if (hazard) begin nlc = 0; nrc = 0; end
        nl = left_lamps(m_side, m_step, brake);
        nr = right_lamps(m_side, m_step, brake);
        @(posedge clk);
        #1;
        m_side = ns; m_step = nst; m_lc = nlc; m_rc = nrc;
        m_l = nl; m_r = nr;
        m_pre = (m_pre + 1) % TD;
        tap_left = 1'b0;
        tap_right = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check("rst_l", l, 3'b000);
        check("rst_r", r, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_tick", tick, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_busy", busy, 1'b0);
        reset = 1'b1;
    endtask

    task automatic run_until(input int side, input int step, input string tag);
        int n = 0;
        while (!(m_side == side && m_step == step) && n < 64) begin
            cycle();
            n++;
        end
        check(tag, n < 64, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit;
        int first;
        model_reset();
        #2 reset = 1'b0;
        #1;
        check("init_l", l, 3'b000);
        check("init_r", r, 3'b000);
        check("init_busy", busy, 1'b0);
        check("init_tick", tick, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Left held: continuous left sweeps.
        left = 1'b1;
        repeat (40) cycle();
        left = 1'b0;
        repeat (16) cycle();

        // One right tap: three full sweeps, then quiet.
        tap_right = 1'b1;
        lit = 0;
        for (int i = 0; i < 60; i++) begin
            if (r != 3'b000) lit++;
            cycle();
        end
        check("tap_lit_cycles", lit, 3 * 3 * TD);
        check("tap_done_busy", busy, 1'b0);
        check("tap_done_r", r, 3'b000);

        // Hazard preempting a left sweep in L2, then dropped during H_ON.
        left = 1'b1;
        run_until(1, 2, "reach_l2");
        hazard = 1'b1;
        left = 1'b0;
        repeat (16) cycle();
        brake = 1'b1;
        repeat (8) cycle();
        run_until(3, 1, "reach_h_on");
        hazard = 1'b0;
        repeat (12) cycle();
        check("brake_idle_l", l, 3'b111);
        check("brake_idle_r", r, 3'b111);
        brake = 1'b0;
        repeat (4) cycle();

        // Brake during a left sweep lights the right side within one clock.
        left = 1'b1;
        run_until(1, 1, "reach_l1");
        brake = 1'b1;
        cycle();
        check("brake_sweep_r", r, 3'b111);
        left = 1'b0;
        repeat (12) cycle();
        brake = 1'b0;
        repeat (12) cycle();

        // Conflicting levels hold IDLE; simultaneous taps are ignored.
        left = 1'b1;
        right = 1'b1;
        repeat (20) cycle();
        check("both_idle_l", l, 3'b000);
        check("both_idle_r", r, 3'b000);
        left = 1'b0;
        right = 1'b0;
        tap_left = 1'b1;
        tap_right = 1'b1;
        cycle();
        check("dual_tap_busy", busy, 1'b0);
        repeat (8) cycle();

        // Reset during R2, then first tick after release.
        right = 1'b1;
        run_until(2, 2, "reach_r2");
        cycle();
        pulse_reset();
        right = 1'b0;
        first = -1;
        for (int k = 0; k < 8; k++) begin
            if (tick && first < 0) first = k;
            cycle();
        end
        check("first_tick_after_reset", first, TD - 1);

        // Randomized levels, taps and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int t;
            if ($urandom_range(0, 29) == 0) left = ~left;
            if ($urandom_range(0, 29) == 0) right = ~right;
            if ($urandom_range(0, 119) == 0) hazard = ~hazard;
            if ($urandom_range(0, 24) == 0) brake = ~brake;
            t = $urandom_range(0, 49);
            if (t == 0) tap_left = 1'b1;
            if (t == 1) tap_right = 1'b1;
            if (t == 2) begin tap_left = 1'b1; tap_right = 1'b1; end
            if ($urandom_range(0, 999) == 0) begin
                tap_left = 1'b0;
                tap_right = 1'b0;
                pulse_reset();
            end else begin
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
